// File: rtl/dsu_bp_wp_unit.sv
// Per-thread breakpoint/watchpoint unit for the Debug Support Unit.
// Compares issued PCs and memory accesses against programmable comparators,
// counts hits, and sequences per-thread halt / resume / single-step.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUNNING  | thread issues normally, halt request low
// ST_HALTED   | thread stopped, halt request high until resume
// ST_STEPPING | thread released for one instruction, halts after it issues
module dsu_bp_wp_unit #(
    parameter int BP_NUMB       = 8,
    parameter int THREAD_NUMB   = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int HIT_CNT_WIDTH = 8,
    localparam int IDX_W        = $clog2(BP_NUMB),
    localparam int TID_W        = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [ADDR_WIDTH-1:0]    cfg_addr,
    input  logic [1:0]               cfg_mode,
    input  logic [THREAD_NUMB-1:0]   cfg_thread_mask,
    input  logic [HIT_CNT_WIDTH-1:0] cfg_count,
    input  logic                     is_instruction_valid,
    input  logic [ADDR_WIDTH-1:0]    is_instruction_pc,
    input  logic [TID_W-1:0]         is_thread_id,
    input  logic                     mem_access_valid,
    input  logic [ADDR_WIDTH-1:0]    mem_access_addr,
    input  logic                     mem_access_is_store,
    input  logic [TID_W-1:0]         mem_access_thread_id,
    input  logic [THREAD_NUMB-1:0]   dsu_single_step,
    input  logic [THREAD_NUMB-1:0]   dsu_resume,
    input  logic                     dsu_hit_status_clear,
    output logic [THREAD_NUMB-1:0]   dsu_halt_request,
    output logic [THREAD_NUMB-1:0]   dsu_halt_by_step,
    output logic [BP_NUMB-1:0]       dsu_hit_status
);

    typedef enum logic [1:0] {
        ST_RUNNING  = 2'd0,
        ST_HALTED   = 2'd1,
        ST_STEPPING = 2'd2
    } thr_state_t;

    localparam logic [1:0] MODE_EXEC = 2'b01;

    logic [ADDR_WIDTH-1:0]    cmp_addr  [BP_NUMB];
    logic [1:0]               cmp_mode  [BP_NUMB];
    logic [THREAD_NUMB-1:0]   cmp_mask  [BP_NUMB];
    logic [HIT_CNT_WIDTH-1:0] cmp_count [BP_NUMB];
    logic [HIT_CNT_WIDTH-1:0] hit_cnt   [BP_NUMB];

    logic [HIT_CNT_WIDTH-1:0] hit_cnt_nxt [BP_NUMB];
    logic [HIT_CNT_WIDTH:0]   hit_sum     [BP_NUMB];
    logic [BP_NUMB-1:0]       wr_sel;
    logic [BP_NUMB-1:0]       exec_match;
    logic [BP_NUMB-1:0]       mem_match;
    logic [BP_NUMB-1:0]       exec_trig;
    logic [BP_NUMB-1:0]       mem_trig;
    logic [THREAD_NUMB-1:0]   thread_trig;
    logic [BP_NUMB-1:0]       hit_status_nxt;

    thr_state_t thr_state [THREAD_NUMB];

    // Comparator match, trigger and saturating hit-count evaluation.
    // A comparator being rewritten this cycle is masked so the old config
    // neither counts nor triggers.
    always_comb begin
        exec_match  = '0;
        mem_match   = '0;
        exec_trig   = '0;
        mem_trig    = '0;
        wr_sel      = '0;
        thread_trig = '0;
        for (int i = 0; i < BP_NUMB; i++) begin
            hit_sum[i]     = '0;
            hit_cnt_nxt[i] = hit_cnt[i];
        end
        for (int i = 0; i < BP_NUMB; i++) begin
            wr_sel[i]     = cfg_we && (cfg_idx == IDX_W'(i));
            exec_match[i] = !wr_sel[i] && (cmp_mode[i] == MODE_EXEC)
                            && is_instruction_valid
                            && cmp_mask[i][is_thread_id]
                            && (is_instruction_pc == cmp_addr[i]);
            mem_match[i]  = !wr_sel[i] && cmp_mode[i][1]
                            && mem_access_valid
                            && (mem_access_is_store == cmp_mode[i][0])
                            && cmp_mask[i][mem_access_thread_id]
                            && (mem_access_addr == cmp_addr[i]);
            exec_trig[i]  = exec_match[i] && (hit_cnt[i] >= cmp_count[i]);
            mem_trig[i]   = mem_match[i] && (hit_cnt[i] >= cmp_count[i]);
            hit_sum[i]    = {1'b0, hit_cnt[i]}
                            + (HIT_CNT_WIDTH+1)'(exec_match[i])
                            + (HIT_CNT_WIDTH+1)'(mem_match[i]);
            if (wr_sel[i])
                hit_cnt_nxt[i] = '0;
            else if (hit_sum[i][HIT_CNT_WIDTH])
                hit_cnt_nxt[i] = '1;
            else
                hit_cnt_nxt[i] = hit_sum[i][HIT_CNT_WIDTH-1:0];
            if (exec_trig[i])
                thread_trig[is_thread_id] = 1'b1;
            if (mem_trig[i])
                thread_trig[mem_access_thread_id] = 1'b1;
        end
        // A new trigger survives a simultaneous clear; a rewrite clears its bit.
        hit_status_nxt = (dsu_hit_status_clear ? '0 : dsu_hit_status)
                         | exec_trig | mem_trig;
        hit_status_nxt = hit_status_nxt & ~wr_sel;
    end

    // Comparator configuration, hit counters and sticky hit status.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BP_NUMB; i++) begin
                cmp_addr[i]  <= '0;
                cmp_mode[i]  <= '0;
                cmp_mask[i]  <= '0;
                cmp_count[i] <= '0;
                hit_cnt[i]   <= '0;
            end
            dsu_hit_status <= '0;
        end else begin
            for (int i = 0; i < BP_NUMB; i++) begin
                hit_cnt[i] <= hit_cnt_nxt[i];
                if (wr_sel[i]) begin
                    cmp_addr[i]  <= cfg_addr;
                    cmp_mode[i]  <= cfg_mode;
                    cmp_mask[i]  <= cfg_thread_mask;
                    cmp_count[i] <= cfg_count;
                end
            end
            dsu_hit_status <= hit_status_nxt;
        end
    end

    // Per-thread run/halt/step state machine with registered halt outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < THREAD_NUMB; t++)
                thr_state[t] <= ST_RUNNING;
            dsu_halt_request <= '0;
            dsu_halt_by_step <= '0;
        end else begin
            for (int t = 0; t < THREAD_NUMB; t++) begin
                case (thr_state[t])
                    ST_RUNNING: begin
                        if (thread_trig[t]) begin
                            thr_state[t]        <= ST_HALTED;
                            dsu_halt_request[t] <= 1'b1;
                            dsu_halt_by_step[t] <= 1'b0;
                        end
                    end
                    ST_HALTED: begin
                        // Trigger beats resume; that counts as a fresh breakpoint halt.
                        if (dsu_resume[t] && thread_trig[t]) begin
                            dsu_halt_by_step[t] <= 1'b0;
                        end else if (dsu_resume[t]) begin
                            thr_state[t]        <= dsu_single_step[t] ? ST_STEPPING
                                                                      : ST_RUNNING;
                            dsu_halt_request[t] <= 1'b0;
                        end
                    end
                    ST_STEPPING: begin
                        if (thread_trig[t]) begin
                            thr_state[t]        <= ST_HALTED;
                            dsu_halt_request[t] <= 1'b1;
                            dsu_halt_by_step[t] <= 1'b0;
                        end else if (is_instruction_valid
                                     && (is_thread_id == TID_W'(t))) begin
                            thr_state[t]        <= ST_HALTED;
                            dsu_halt_request[t] <= 1'b1;
                            dsu_halt_by_step[t] <= 1'b1;
                        end
                    end
                    default: begin
                        thr_state[t]        <= ST_RUNNING;
                        dsu_halt_request[t] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsu_bp_wp_unit.sv
// Directed bench for dsu_bp_wp_unit: breakpoints, watchpoints, stepping,
// boundary collisions, counter saturation and mid-run reset.
module tb_dsu_bp_wp_unit;

    localparam int BP_NUMB       = 8;
    localparam int THREAD_NUMB   = 4;
    localparam int ADDR_WIDTH    = 32;
    localparam int HIT_CNT_WIDTH = 8;

    logic                     clk;
    logic                     reset;
    logic                     cfg_we;
    logic [2:0]               cfg_idx;
    logic [ADDR_WIDTH-1:0]    cfg_addr;
    logic [1:0]               cfg_mode;
    logic [THREAD_NUMB-1:0]   cfg_thread_mask;
    logic [HIT_CNT_WIDTH-1:0] cfg_count;
    logic                     is_instruction_valid;
    logic [ADDR_WIDTH-1:0]    is_instruction_pc;
    logic [1:0]               is_thread_id;
    logic                     mem_access_valid;
    logic [ADDR_WIDTH-1:0]    mem_access_addr;
    logic                     mem_access_is_store;
    logic [1:0]               mem_access_thread_id;
    logic [THREAD_NUMB-1:0]   dsu_single_step;
    logic [THREAD_NUMB-1:0]   dsu_resume;
    logic                     dsu_hit_status_clear;
    logic [THREAD_NUMB-1:0]   dsu_halt_request;
    logic [THREAD_NUMB-1:0]   dsu_halt_by_step;
    logic [BP_NUMB-1:0]       dsu_hit_status;

    int errors = 0;
    int checks = 0;

    dsu_bp_wp_unit #(
        .BP_NUMB(BP_NUMB), .THREAD_NUMB(THREAD_NUMB),
        .ADDR_WIDTH(ADDR_WIDTH), .HIT_CNT_WIDTH(HIT_CNT_WIDTH)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_mode(cfg_mode), .cfg_thread_mask(cfg_thread_mask), .cfg_count(cfg_count),
        .is_instruction_valid(is_instruction_valid), .is_instruction_pc(is_instruction_pc),
        .is_thread_id(is_thread_id),
        .mem_access_valid(mem_access_valid), .mem_access_addr(mem_access_addr),
        .mem_access_is_store(mem_access_is_store), .mem_access_thread_id(mem_access_thread_id),
        .dsu_single_step(dsu_single_step), .dsu_resume(dsu_resume),
        .dsu_hit_status_clear(dsu_hit_status_clear),
        .dsu_halt_request(dsu_halt_request), .dsu_halt_by_step(dsu_halt_by_step),
        .dsu_hit_status(dsu_hit_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [2:0] idx, input logic [31:0] addr,
                           input logic [1:0] mode, input logic [3:0] mask,
                           input logic [7:0] cnt);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = addr;
        cfg_mode = mode; cfg_thread_mask = mask; cfg_count = cnt;
    endtask

    task automatic wr_cmp(input logic [2:0] idx, input logic [31:0] addr,
                          input logic [1:0] mode, input logic [3:0] mask,
                          input logic [7:0] cnt);
        set_cfg(idx, addr, mode, mask, cnt);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [1:0] tid);
        is_instruction_valid = 1'b1; is_instruction_pc = pc; is_thread_id = tid;
        tick();
        is_instruction_valid = 1'b0;
    endtask

    task automatic mem_op(input logic [31:0] addr, input logic store, input logic [1:0] tid);
        mem_access_valid = 1'b1; mem_access_addr = addr;
        mem_access_is_store = store; mem_access_thread_id = tid;
        tick();
        mem_access_valid = 1'b0;
    endtask

    task automatic resume(input logic [3:0] mask, input logic [3:0] step);
        dsu_resume = mask; dsu_single_step = step;
        tick();
        dsu_resume = '0; dsu_single_step = '0;
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_mode = '0;
        cfg_thread_mask = '0; cfg_count = '0;
        is_instruction_valid = 1'b0; is_instruction_pc = '0; is_thread_id = '0;
        mem_access_valid = 1'b0; mem_access_addr = '0; mem_access_is_store = 1'b0;
        mem_access_thread_id = '0; dsu_single_step = '0; dsu_resume = '0;
        dsu_hit_status_clear = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_halt", 32'(dsu_halt_request), 32'h0);
        chk("rst_step", 32'(dsu_halt_by_step), 32'h0);
        chk("rst_status", 32'(dsu_hit_status), 32'h0);

        // exec breakpoint masked to thread 1
        wr_cmp(3'd0, 32'h100, 2'b01, 4'b0010, 8'd0);
        issue(32'h100, 2'd0);
        chk("exec_t0_masked", 32'(dsu_halt_request), 32'h0);
        issue(32'h100, 2'd1);
        chk("exec_t1_halt", 32'(dsu_halt_request), 32'h2);
        chk("exec_t1_status", 32'(dsu_hit_status), 32'h01);
        resume(4'b0010, 4'b0000);
        chk("exec_t1_resume", 32'(dsu_halt_request), 32'h0);

        // store watch with count 2; loads ignored
        wr_cmp(3'd3, 32'h2000, 2'b11, 4'b1111, 8'd2);
        mem_op(32'h2000, 1'b1, 2'd2);
        chk("st_1", 32'(dsu_halt_request), 32'h0);
        mem_op(32'h2000, 1'b0, 2'd2);
        chk("st_load", 32'(dsu_halt_request), 32'h0);
        mem_op(32'h2000, 1'b1, 2'd2);
        chk("st_2", 32'(dsu_halt_request), 32'h0);
        mem_op(32'h2000, 1'b1, 2'd2);
        chk("st_3_halt", 32'(dsu_halt_request), 32'h4);
        chk("st_3_status", 32'(dsu_hit_status), 32'h09);
        dsu_hit_status_clear = 1'b1;
        tick();
        dsu_hit_status_clear = 1'b0;
        chk("status_clear", 32'(dsu_hit_status), 32'h0);
        dsu_hit_status_clear = 1'b1;
        mem_op(32'h2000, 1'b1, 2'd2);
        dsu_hit_status_clear = 1'b0;
        chk("clear_vs_trig", 32'(dsu_hit_status), 32'h08);
        chk("halted_stays", 32'(dsu_halt_request), 32'h4);
        resume(4'b0100, 4'b0000);
        chk("st_resume", 32'(dsu_halt_request), 32'h0);

        // single step on thread 0
        wr_cmp(3'd1, 32'h300, 2'b01, 4'b0001, 8'd0);
        issue(32'h300, 2'd0);
        chk("t0_halt", 32'(dsu_halt_request), 32'h1);
        resume(4'b0001, 4'b0001);
        chk("t0_stepping", 32'(dsu_halt_request), 32'h0);
        issue(32'h400, 2'd0);
        chk("step_halt", 32'(dsu_halt_request), 32'h1);
        chk("step_by_step", 32'(dsu_halt_by_step), 32'h1);
        issue(32'h404, 2'd0);
        chk("step_second", 32'(dsu_halt_request), 32'h1);
        resume(4'b0001, 4'b0000);
        chk("plain_resume", 32'(dsu_halt_request), 32'h0);
        chk("by_step_hold", 32'(dsu_halt_by_step), 32'h1);
        issue(32'h408, 2'd0);
        chk("t0_running", 32'(dsu_halt_request), 32'h0);
        issue(32'h300, 2'd0);
        chk("bp_halt_again", 32'(dsu_halt_request), 32'h1);
        chk("by_step_clear", 32'(dsu_halt_by_step), 32'h0);
        resume(4'b0001, 4'b0000);

        // resume and trigger collide on thread 1
        issue(32'h100, 2'd1);
        chk("t1_halt", 32'(dsu_halt_request), 32'h2);
        dsu_resume = 4'b0010;
        issue(32'h100, 2'd1);
        dsu_resume = '0;
        chk("resume_vs_trig", 32'(dsu_halt_request), 32'h2);
        resume(4'b0010, 4'b0000);
        chk("t1_resume", 32'(dsu_halt_request), 32'h0);
        resume(4'b0100, 4'b0100);
        chk("resume_running", 32'(dsu_halt_request), 32'h0);
        issue(32'h500, 2'd2);
        chk("resume_running_nostep", 32'(dsu_halt_request), 32'h0);

        // cfg write colliding with a match on comparator 5
        wr_cmp(3'd5, 32'h500, 2'b01, 4'b1111, 8'd0);
        set_cfg(3'd5, 32'h500, 2'b01, 4'b1111, 8'd1);
        issue(32'h500, 2'd3);
        cfg_we = 1'b0;
        chk("wr_vs_match_halt", 32'(dsu_halt_request), 32'h0);
        chk("wr_vs_match_stat", 32'(dsu_hit_status[5]), 32'h0);
        issue(32'h500, 2'd3);
        chk("wr_cnt_zero", 32'(dsu_halt_request), 32'h0);
        issue(32'h500, 2'd3);
        chk("wr_cnt_trig", 32'(dsu_halt_request), 32'h8);
        chk("wr_cnt_stat", 32'(dsu_hit_status[5]), 32'h1);

        // hit counter saturation, threshold 255 on thread 2
        wr_cmp(3'd6, 32'h600, 2'b01, 4'b0100, 8'd255);
        for (int k = 0; k < 255; k++) issue(32'h600, 2'd2);
        chk("sat_255_nohalt", 32'(dsu_halt_request[2]), 32'h0);
        issue(32'h600, 2'd2);
        chk("sat_256_halt", 32'(dsu_halt_request[2]), 32'h1);
        resume(4'b0100, 4'b0000);
        chk("sat_resume", 32'(dsu_halt_request[2]), 32'h0);
        issue(32'h600, 2'd2);
        chk("sat_257_halt", 32'(dsu_halt_request[2]), 32'h1);

        // reset mid-operation with threads 0, 2 and 3 halted
        issue(32'h300, 2'd0);
        chk("pre_rst_halt", 32'(dsu_halt_request), 32'hD);
        reset = 1'b1;
        issue(32'h300, 2'd0);
        reset = 1'b0;
        chk("mid_rst_halt", 32'(dsu_halt_request), 32'h0);
        chk("mid_rst_step", 32'(dsu_halt_by_step), 32'h0);
        chk("mid_rst_status", 32'(dsu_hit_status), 32'h0);
        issue(32'h300, 2'd0);
        chk("post_rst_t0", 32'(dsu_halt_request), 32'h0);
        issue(32'h500, 2'd3);
        chk("post_rst_t3", 32'(dsu_halt_request), 32'h0);
        mem_op(32'h2000, 1'b1, 2'd2);
        chk("post_rst_st", 32'(dsu_halt_request), 32'h0);
        chk("post_rst_status", 32'(dsu_hit_status), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
